// File: rtl/eth_pkg.sv
// eth_pkg: MAC Control PAUSE constants, RX parser state encoding and a DA byte-lane helper.
package eth_pkg;

    localparam logic [15:0] ETH_TYPE_MAC_CTRL = 16'h8808;
    localparam logic [15:0] MAC_CTRL_OP_PAUSE = 16'h0001;
    localparam logic [47:0] PAUSE_MCAST_DA    = 48'h0180C2000001;
    localparam int          PAUSE_MIN_BYTES   = 18;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DA,
        ST_SA,
        ST_TYPE,
        ST_OPCODE,
        ST_PTIME,
        ST_WAIT_LAST,
        ST_DISCARD
    } rx_state_e;

    // Byte idx of a 48-bit address in wire order (idx 0 = first byte); idx > 5 yields 0.
    function automatic logic [7:0] eth_byte(input logic [47:0] addr, input logic [2:0] idx);
        logic [47:0] s;
        s = addr << (8 * idx);
        return s[47:40];
    endfunction

endpackage

// File: rtl/pause_quanta_timer.sv
// pause_quanta_timer: counts down pause quanta of QUANTA_CYCLES clocks; a load always wins.
module pause_quanta_timer #(
    parameter int QUANTA_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] quanta_left,
    output logic        hold
);

    localparam int CW = $clog2(QUANTA_CYCLES + 1);

    logic [CW-1:0] cyc_q, cyc_d;
    logic [15:0]   quanta_q, quanta_d;
    logic          hold_q;
    logic          tc;

    assign tc = cyc_q == CW'(QUANTA_CYCLES - 1);

    always_comb begin
        quanta_d = load ? load_val : (tc && quanta_q != 16'd0) ? quanta_q - 16'd1 : quanta_q;
        cyc_d    = (load || tc || quanta_q == 16'd0) ? '0 : cyc_q + CW'(1);
    end

    // hold tracks the next quanta value so it moves on the same edge as the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q    <= '0;
            quanta_q <= '0;
            hold_q   <= 1'b0;
        end else begin
            cyc_q    <= cyc_d;
            quanta_q <= quanta_d;
            hold_q   <= quanta_d != 16'd0;
        end
    end

    assign quanta_left = quanta_q;
    assign hold        = hold_q;

endmodule

// File: rtl/pause_frame_rx.sv
// pause_frame_rx: taps the MAC RX stream, accepts 802.3x PAUSE frames and holds off TX for pause_time quanta.
// Define PAUSE_FRAME_STATS_EN to add pause_frm_cnt / pause_drop_cnt counters.
module pause_frame_rx
    import eth_pkg::*;
#(
    parameter int          QUANTA_CYCLES = 64,
    parameter logic [47:0] STATION_ADDR  = 48'h000000000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_mac_data,
    input  logic        rx_mac_valid,
    input  logic        rx_mac_last,
    input  logic        rx_frame_err,
    output logic        tx_pause_hold,
    output logic [15:0] pause_quanta_left,
    output logic        pause_frame_det,
    output logic [47:0] pause_src_addr
`ifdef PAUSE_FRAME_STATS_EN
    ,
    output logic [15:0] pause_frm_cnt,
    output logic [15:0] pause_drop_cnt
`endif
);

    rx_state_e   state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        mc_ok_q, mc_ok_d, st_ok_q, st_ok_d, armed_q, armed_d;
    logic [47:0] sa_q, sa_d, src_q;
    logic [15:0] ptime_q, ptime_d, load_val;
    logic        det_q;
    logic        mc_hit, st_hit, fld_hit, last_v, accept;
    logic [7:0]  fld_byte;

    assign mc_hit   = rx_mac_data == eth_byte(PAUSE_MCAST_DA, cnt_q[2:0]);
    assign st_hit   = rx_mac_data == eth_byte(STATION_ADDR, cnt_q[2:0]);
    assign fld_byte = state_q == ST_TYPE
                    ? (cnt_q[0] ? ETH_TYPE_MAC_CTRL[7:0] : ETH_TYPE_MAC_CTRL[15:8])
                    : (cnt_q[0] ? MAC_CTRL_OP_PAUSE[7:0] : MAC_CTRL_OP_PAUSE[15:8]);
    assign fld_hit  = rx_mac_data == fld_byte;
    assign last_v   = rx_mac_valid && rx_mac_last;
    // PTIME only reaches the length threshold on its second byte.
    assign accept   = last_v && !rx_frame_err && cnt_q >= 5'(PAUSE_MIN_BYTES - 1)
                   && (state_q == ST_WAIT_LAST || state_q == ST_PTIME);
    assign load_val = state_q == ST_PTIME ? {ptime_q[15:8], rx_mac_data} : ptime_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mc_ok_d = mc_ok_q;
        st_ok_d = st_ok_q;
        armed_d = armed_q;
        sa_d    = sa_q;
        ptime_d = ptime_q;
        if (rx_mac_valid) begin
            cnt_d   = rx_mac_last ? 5'd0 : cnt_q == 5'd20 ? cnt_q : cnt_q + 5'd1;
            armed_d = armed_q | rx_mac_last;
            case (state_q)
                ST_IDLE: if (armed_q) begin
                    mc_ok_d = mc_hit;
                    st_ok_d = st_hit;
                    state_d = ST_DA;
                end
                ST_DA: begin
                    mc_ok_d = mc_ok_q && mc_hit;
                    st_ok_d = st_ok_q && st_hit;
                    if (cnt_q == 5'd5) state_d = (mc_ok_d || st_ok_d) ? ST_SA : ST_DISCARD;
                end
                ST_SA: begin
                    sa_d = {sa_q[39:0], rx_mac_data};
                    if (cnt_q == 5'd11) state_d = ST_TYPE;
                end
                ST_TYPE:   state_d = !fld_hit ? ST_DISCARD : cnt_q[0] ? ST_OPCODE : ST_TYPE;
                ST_OPCODE: state_d = !fld_hit ? ST_DISCARD : cnt_q[0] ? ST_PTIME : ST_OPCODE;
                ST_PTIME: begin
                    ptime_d = cnt_q[0] ? {ptime_q[15:8], rx_mac_data} : {rx_mac_data, ptime_q[7:0]};
                    if (cnt_q[0]) state_d = ST_WAIT_LAST;
                end
                default: ;
            endcase
            if (rx_mac_last) state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mc_ok_q <= 1'b0;
            st_ok_q <= 1'b0;
            armed_q <= 1'b0;
            sa_q    <= '0;
            ptime_q <= '0;
            det_q   <= 1'b0;
            src_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mc_ok_q <= mc_ok_d;
            st_ok_q <= st_ok_d;
            armed_q <= armed_d;
            sa_q    <= sa_d;
            ptime_q <= ptime_d;
            det_q   <= accept;
            if (accept) src_q <= sa_q;
        end
    end

    pause_quanta_timer #(.QUANTA_CYCLES(QUANTA_CYCLES)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (accept),
        .load_val   (load_val),
        .quanta_left(pause_quanta_left),
        .hold       (tx_pause_hold)
    );

    assign pause_frame_det = det_q;
    assign pause_src_addr  = src_q;

`ifdef PAUSE_FRAME_STATS_EN
    logic        hdr_ok;
    logic [15:0] frm_q, drop_q;

    // Header is known good once past OPCODE, or on the final opcode byte itself.
    assign hdr_ok = state_q == ST_PTIME || state_q == ST_WAIT_LAST
                 || (state_q == ST_OPCODE && cnt_q[0] && fld_hit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_q  <= '0;
            drop_q <= '0;
        end else begin
            if (accept && frm_q != 16'hFFFF) frm_q <= frm_q + 16'd1;
            if (last_v && hdr_ok && !accept && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
        end
    end

    assign pause_frm_cnt  = frm_q;
    assign pause_drop_cnt = drop_q;
`endif

endmodule
